// File: rtl/pkt_merge.sv
// pkt_merge: merges the data-path AXI-Stream and a FIFO-buffered control-path stream at packet boundaries.
// Build option: define PKT_MERGE_DROP_CNT_EN to add the ctl_drop_cnt output.
module pkt_merge #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_CTL_FIFO_DEPTH     = 32,
    parameter int C_CTL_MAX_BEATS      = 4
) (
    input  logic                                 clk,
    input  logic                                 areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       c_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_s_axis_tuser,
    input  logic                                 c_s_axis_tvalid,
    input  logic                                 c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast
`ifdef PKT_MERGE_DROP_CNT_EN
    ,
    output logic [31:0]                          ctl_drop_cnt
`endif
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int EW = 1 + UW + KW + DW;
    localparam int AW = $clog2(C_CTL_FIFO_DEPTH);
    localparam int IW = $clog2(C_CTL_MAX_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FWD_DATA = 2'd1,
        FWD_CTL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pkt_cnt_q, pkt_cnt_d;
    logic            ctl_in_pkt_q, ctl_in_pkt_d, ctl_admit_q, ctl_admit_d;
    logic [IW-1:0]   ctl_idx_q, ctl_idx_d;
    logic [DW-1:0]   m_tdata_q, m_tdata_d;
    logic [KW-1:0]   m_tkeep_q, m_tkeep_d;
    logic [UW-1:0]   m_tuser_q, m_tuser_d;
    logic            m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;

    logic [EW-1:0]   ctl_mem [C_CTL_FIFO_DEPTH];
    logic [EW-1:0]   rd_data_s;
    logic [AW:0]     free_s;
    logic [IW-1:0]   idx_s;
    logic            load_en_s, admit_s, wr_en_s, wr_last_s, pop_s, pop_last_s;

    assign load_en_s     = !m_tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q == FWD_DATA) && load_en_s;
    assign free_s        = (AW+1)'(C_CTL_FIFO_DEPTH) - (wr_ptr_q - rd_ptr_q);
    assign rd_data_s     = ctl_mem[rd_ptr_q[AW-1:0]];
    assign pop_last_s    = rd_data_s[EW-1];
    assign pop_s         = (state_q == FWD_CTL) && load_en_s;

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;

    // Control write side: admission on the first beat, truncation beyond the beat limit.
    always_comb begin
        admit_s   = ctl_in_pkt_q ? ctl_admit_q : (free_s >= (AW+1)'(C_CTL_MAX_BEATS));
        idx_s     = ctl_in_pkt_q ? ctl_idx_q : {IW{1'b0}};
        wr_en_s   = c_s_axis_tvalid && admit_s && (idx_s < IW'(C_CTL_MAX_BEATS));
        wr_last_s = c_s_axis_tlast || (idx_s == IW'(C_CTL_MAX_BEATS - 1));
        wr_ptr_d  = wr_en_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
        if (c_s_axis_tvalid) begin
            ctl_in_pkt_d = !c_s_axis_tlast;
            ctl_admit_d  = admit_s;
            ctl_idx_d    = (idx_s < IW'(C_CTL_MAX_BEATS)) ? (idx_s + IW'(1)) : idx_s;
        end else begin
            ctl_in_pkt_d = ctl_in_pkt_q;
            ctl_admit_d  = ctl_admit_q;
            ctl_idx_d    = ctl_idx_q;
        end
        if ((wr_en_s && wr_last_s) && !(pop_s && pop_last_s)) begin
            pkt_cnt_d = pkt_cnt_q + {{AW{1'b0}}, 1'b1};
        end else if (!(wr_en_s && wr_last_s) && (pop_s && pop_last_s)) begin
            pkt_cnt_d = pkt_cnt_q - {{AW{1'b0}}, 1'b1};
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Arbiter and output register: grants only at packet boundaries, loads when the slot frees.
    always_comb begin
        state_d    = state_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tuser_d  = m_tuser_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        case (state_q)
            IDLE: begin
                m_tvalid_d = load_en_s ? 1'b0 : m_tvalid_q;
                if (pkt_cnt_q != {(AW+1){1'b0}}) begin
                    state_d = FWD_CTL;
                end else if (s_axis_tvalid) begin
                    state_d = FWD_DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            FWD_DATA: begin
                if (s_axis_tvalid && s_axis_tready) begin
                    {m_tlast_d, m_tuser_d, m_tkeep_d, m_tdata_d} =
                        {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
                    m_tvalid_d = 1'b1;
                    state_d    = s_axis_tlast ? IDLE : FWD_DATA;
                end else if (load_en_s) begin
                    m_tvalid_d = 1'b0;
                end else begin
                    m_tvalid_d = m_tvalid_q;
                end
            end
            FWD_CTL: begin
                if (load_en_s) begin
                    {m_tlast_d, m_tuser_d, m_tkeep_d, m_tdata_d} = rd_data_s;
                    m_tvalid_d = 1'b1;
                    state_d    = pop_last_s ? IDLE : FWD_CTL;
                end else begin
                    m_tvalid_d = m_tvalid_q;
                end
            end
            default: begin
                state_d    = IDLE;
                m_tvalid_d = 1'b0;
            end
        endcase
    end

    // Control FIFO storage; contents are invalidated by the pointer reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ctl_mem[wr_ptr_q[AW-1:0]] <= {wr_last_s, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tdata};
        end
    end

`ifdef PKT_MERGE_DROP_CNT_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        drop_evt_s;

    assign ctl_drop_cnt = drop_cnt_q;

    // A rejected packet or a truncated one each count once, saturating.
    always_comb begin
        drop_evt_s = (c_s_axis_tvalid && !ctl_in_pkt_q && !admit_s) ||
                     (wr_en_s && !c_s_axis_tlast && (idx_s == IW'(C_CTL_MAX_BEATS - 1)));
        if (drop_evt_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end
`endif

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= {(AW+1){1'b0}};
            rd_ptr_q     <= {(AW+1){1'b0}};
            pkt_cnt_q    <= {(AW+1){1'b0}};
            ctl_in_pkt_q <= 1'b0;
            ctl_admit_q  <= 1'b0;
            ctl_idx_q    <= {IW{1'b0}};
            m_tdata_q    <= {DW{1'b0}};
            m_tkeep_q    <= {KW{1'b0}};
            m_tuser_q    <= {UW{1'b0}};
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
`ifdef PKT_MERGE_DROP_CNT_EN
            drop_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            ctl_in_pkt_q <= ctl_in_pkt_d;
            ctl_admit_q  <= ctl_admit_d;
            ctl_idx_q    <= ctl_idx_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tuser_q    <= m_tuser_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
`ifdef PKT_MERGE_DROP_CNT_EN
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_pkt_merge.sv
// tb_pkt_merge: directed and randomized checks of pkt_merge against a packet-level scoreboard and FIFO-occupancy model.
module tb_pkt_merge;
    localparam int DW = 512, UW = 128, KW = 64, DEPTH = 32, MAXB = 4;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;
    typedef struct packed {
        logic  v;
        beat_t b;
    } cstim_t;

    logic clk = 1'b0;
    logic areset;
    logic [DW-1:0] s_axis_tdata, c_s_axis_tdata, m_axis_tdata;
    logic [KW-1:0] s_axis_tkeep, c_s_axis_tkeep, m_axis_tkeep;
    logic [UW-1:0] s_axis_tuser, c_s_axis_tuser, m_axis_tuser;
    logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic c_s_axis_tvalid, c_s_axis_tlast;
    logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
`ifdef PKT_MERGE_DROP_CNT_EN
    logic [31:0] ctl_drop_cnt;
`endif

    always #5 clk = ~clk;

    pkt_merge dut (
        .clk(clk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tuser(c_s_axis_tuser),
        .c_s_axis_tvalid(c_s_axis_tvalid), .c_s_axis_tlast(c_s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
`ifdef PKT_MERGE_DROP_CNT_EN
        , .ctl_drop_cnt(ctl_drop_cnt)
`endif
    );

    beat_t  ds_q[$], exp_d_q[$], exp_c_q[$];
    cstim_t cs_q[$];
    int n_cmp = 0, n_mis = 0;
    int c_written = 0, c_out_beats = 0, c_out_pkts = 0, exp_drops = 0, c_idx = 0, out_src = 0;
    bit c_in_pkt = 0, c_admit = 0;
    bit rdy_rand = 0, rdy_fix = 1;
    int gap_pct = 0;
    bit last_acc, last_sready;
    beat_t last_acc_beat;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [7:0] tag, input logic [7:0] lo, input logic last);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.data[i*32 +: 32] = $urandom;
        b.data[DW-1 -: 8] = tag;
        b.data[7:0] = lo;
        b.keep = {$urandom, $urandom};
        b.user = {$urandom, $urandom, $urandom, $urandom};
        b.last = last;
        return b;
    endfunction

    function automatic beat_t cur_out();
        return {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
    endfunction

    task automatic push_dpkt(input int n, input logic [7:0] lo0);
        for (int i = 0; i < n; i++) ds_q.push_back(mk_beat(8'hD0, 8'(lo0 * (i + 1)), i == n - 1));
    endtask

    task automatic push_cpkt(input int n, input logic [7:0] lo0, input int gp);
        cstim_t c;
        for (int i = 0; i < n; i++) begin
            if (gp > 0 && $urandom_range(0, 99) < gp) begin
                c = '0;
                cs_q.push_back(c);
            end
            c.v = 1'b1;
            c.b = mk_beat(8'hC0, 8'(lo0 + 8'(i)), i == n - 1);
            cs_q.push_back(c);
        end
    endtask

    // Output scoreboard: whole packets from one source, each source in its own order.
    task automatic check_out(input beat_t o);
        if (out_src == 0) out_src = (o.data[DW-1 -: 8] == 8'hC0) ? 2 : 1;
        if (out_src == 2) begin
            if (exp_c_q.size() == 0) chk("ctl_extra_beat", o, '0);
            else chk("ctl_beat", o, exp_c_q.pop_front());
            c_out_beats++;
            if (o.last) c_out_pkts++;
        end else begin
            if (exp_d_q.size() == 0) chk("data_extra_beat", o, '0);
            else chk("data_beat", o, exp_d_q.pop_front());
        end
        if (o.last) out_src = 0;
    endtask

    // Control-path model: occupancy = stored beats minus beats already moved into the output register.
    task automatic model_ctl(input beat_t cb, input int occ);
        beat_t e;
        if (!c_in_pkt) begin
            c_admit = (DEPTH - occ) >= MAXB;
            c_idx = 0;
            if (!c_admit) exp_drops++;
        end
        if (c_admit && c_idx < MAXB) begin
            e = cb;
            if (c_idx == MAXB - 1) begin
                if (!e.last) exp_drops++;
                e.last = 1'b1;
            end
            exp_c_q.push_back(e);
            c_written++;
        end
        if (c_idx < MAXB) c_idx++;
        c_in_pkt = !cb.last;
    endtask

    task automatic tick();
        beat_t held, cb;
        bit oxf, stall;
        int held_c;
        s_axis_tvalid = (ds_q.size() > 0) && !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
        if (ds_q.size() > 0) {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata} = ds_q[0];
        if (cs_q.size() > 0) begin
            c_s_axis_tvalid = cs_q[0].v;
            cb = cs_q[0].b;
            {c_s_axis_tlast, c_s_axis_tuser, c_s_axis_tkeep, c_s_axis_tdata} = cb;
        end else begin
            c_s_axis_tvalid = 1'b0;
            cb = '0;
        end
        m_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
        #1;
        last_sready = s_axis_tready;
        last_acc = s_axis_tvalid && s_axis_tready;
        oxf = m_axis_tvalid && m_axis_tready;
        stall = m_axis_tvalid && !m_axis_tready;
        held = cur_out();
        held_c = (m_axis_tvalid && held.data[DW-1 -: 8] == 8'hC0) ? 1 : 0;
        if (c_s_axis_tvalid) model_ctl(cb, c_written - c_out_beats - held_c);
        if (cs_q.size() > 0) void'(cs_q.pop_front());
        if (last_acc) begin
            last_acc_beat = ds_q.pop_front();
            exp_d_q.push_back(last_acc_beat);
        end
        if (oxf) check_out(held);
        @(posedge clk);
        @(negedge clk);
        if (last_acc) chk("latency", {m_axis_tvalid, cur_out()}, {1'b1, last_acc_beat});
        if (stall) chk("stall_hold", {m_axis_tvalid, cur_out()}, {1'b1, held});
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((ds_q.size() || cs_q.size() || exp_d_q.size() || exp_c_q.size() || m_axis_tvalid) && k < bound) begin
            tick();
            k++;
        end
        chk("drain_complete", {ds_q.size() != 0, cs_q.size() != 0, exp_d_q.size() != 0, exp_c_q.size() != 0, m_axis_tvalid}, 5'b0);
    endtask

    task automatic wait_acc(input string tag, input bit need_last);
        int k = 0;
        bit seen = 0;
        while (!seen && k < 40) begin
            tick();
            seen = last_acc && (!need_last || last_acc_beat.last);
            k++;
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic chk_drops();
`ifdef PKT_MERGE_DROP_CNT_EN
        chk("ctl_drop_cnt", ctl_drop_cnt, 32'(exp_drops));
`endif
    endtask

    initial begin
        int k, p0, o0;
        bit done;
        areset = 1'b1;
        {s_axis_tvalid, s_axis_tlast, c_s_axis_tvalid, c_s_axis_tlast, m_axis_tready} = '0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        c_s_axis_tdata = '0; c_s_axis_tkeep = '0; c_s_axis_tuser = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, m_axis_tuser, s_axis_tready}, '0);
        chk_drops();
        areset = 1'b0;
        @(negedge clk);

        // Data only: 0x11/0x22/0x33, then exactly one idle bubble before the next packet.
        push_dpkt(3, 8'h11);
        push_dpkt(2, 8'h05);
        wait_acc("data_tlast_seen", 1'b1);
        chk("data_last_low_byte", {m_axis_tlast, m_axis_tdata[7:0]}, {1'b1, 8'h33});
        tick();
        chk("bubble_no_accept", {s_axis_tvalid, last_acc}, 2'b10);
        tick();
        chk("after_bubble_accept", last_acc, 1'b1);
        drain(100);

        // Control arrives mid data packet: data finishes, control goes next, data waits.
        push_dpkt(4, 8'h21);
        push_dpkt(2, 8'h31);
        wait_acc("prio_first_data", 1'b0);
        push_cpkt(2, 8'hA1, 0);
        wait_acc("prio_data_tlast", 1'b1);
        p0 = c_out_pkts;
        k = 0;
        done = 0;
        while (!done && k < 20) begin
            tick();
            chk("prio_data_held", last_acc, 1'b0);
            done = (c_out_pkts != p0);
            k++;
        end
        chk("prio_ctl_drained", done, 1'b1);
        drain(100);

        // Back-pressure pattern 1,0,0,1 inside a data packet.
        push_dpkt(4, 8'h41);
        wait_acc("bp_first", 1'b0);
        rdy_fix = 1; tick();
        rdy_fix = 0; tick(); chk("bp_tready_low1", last_sready, 1'b0);
        rdy_fix = 0; tick(); chk("bp_tready_low2", last_sready, 1'b0);
        rdy_fix = 1; tick();
        drain(100);

        // Overflow: 9 four-beat control packets into a stalled output.
        rdy_fix = 0;
        p0 = c_out_pkts;
        for (int i = 0; i < 9; i++) push_cpkt(4, 8'(i * 16), 0);
        repeat (40) tick();
        chk_drops();
        rdy_fix = 1;
        drain(200);
        chk("ovf_pkts_out", c_out_pkts - p0, 8);

        // Truncation: 6-beat control packet leaves as 4 beats with tlast on the 4th.
        o0 = c_out_beats;
        push_cpkt(6, 8'h60, 0);
        drain(100);
        chk("trunc_beats", c_out_beats - o0, MAXB);
        chk_drops();

        // Reset during beat 2 of a 3-beat data packet.
        push_dpkt(3, 8'h71);
        wait_acc("rst_first_beat", 1'b0);
        areset = 1'b1;
        #1;
        chk("rst_mid_outputs", {m_axis_tvalid, s_axis_tready}, 2'b00);
        ds_q.delete(); cs_q.delete(); exp_d_q.delete(); exp_c_q.delete();
        c_written = 0; c_out_beats = 0; c_in_pkt = 0; out_src = 0; exp_drops = 0;
        @(negedge clk);
        areset = 1'b0;
        push_dpkt(3, 8'h81);
        drain(100);
        chk_drops();

        // Randomized mix of both sources with random stalls and gaps.
        rdy_rand = 1;
        gap_pct = 20;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) != 0) push_dpkt($urandom_range(1, 5), 8'($urandom));
            if ($urandom_range(0, 1) != 0) push_cpkt($urandom_range(1, 6), 8'($urandom), 25);
            repeat ($urandom_range(8, 24)) tick();
        end
        rdy_rand = 0;
        rdy_fix = 1;
        gap_pct = 0;
        drain(3000);
        chk_drops();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/pkt_merge.md
Name: pkt_merge

Overview:
- Egress-side counterpart of the ingress packet filter.
- Merges two AXI-Stream sources back onto one output stream: the data-path stream leaving the RMT pipeline, and the control-path stream carrying control/response packets (UDP port 0xf2f1 traffic).
- The control source has no back-pressure, so its packets are held in an internal FIFO. The two sources are arbitrated at packet boundaries only, so packets are never interleaved.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, tdata width; tkeep width is C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- C_CTL_FIFO_DEPTH, 32, control FIFO depth in beats; power of two, minimum 8.
- C_CTL_MAX_BEATS, 4, maximum accepted control packet length in beats; must be ≤ C_CTL_FIFO_DEPTH.

Ports:
- clk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  512  data-path beat
- s_axis_tkeep  in  64  byte enables
- s_axis_tuser  in  128  metadata
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  data-path ready
- s_axis_tlast  in  1  last beat of packet
- c_s_axis_tdata  in  512  control-path beat
- c_s_axis_tkeep  in  64  byte enables
- c_s_axis_tuser  in  128  metadata
- c_s_axis_tvalid  in  1  beat valid; no ready, every valid beat is presented exactly once
- c_s_axis_tlast  in  1  last beat of control packet
- m_axis_tdata  out  512  merged output beat (registered)
- m_axis_tkeep  out  64  byte enables
- m_axis_tuser  out  128  metadata
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of packet

Behaviour:
- Reset (areset=1, asynchronous): all m_axis_* = 0; s_axis_tready = 0; FIFO pointers, packet count and state cleared; state = IDLE.
  - Reset asserted mid-packet discards all buffered and in-flight beats.
  - After release, the first beat of any stream is treated as a packet start.
- Output register: loads when (!m_axis_tvalid || m_axis_tready). It holds data stable while m_axis_tvalid && !m_axis_tready.
- State machine (IDLE, FWD_DATA, FWD_CTL):
  - IDLE: if ctl_pkt_cnt > 0, go to FWD_CTL (control has priority). Else if s_axis_tvalid, go to FWD_DATA. Else stay. The grant takes effect the next cycle; IDLE moves no beat.
  - FWD_DATA: s_axis_tready = (!m_axis_tvalid || m_axis_tready), combinational from m_axis_tready. Each accepted beat is loaded into the output register. Return to IDLE after the beat with s_axis_tlast=1 is accepted.
  - FWD_CTL: pop one FIFO beat per output load. Return to IDLE after popping the tlast beat. s_axis_tready = 0.
  - In IDLE, s_axis_tready = 0.
- Latency: one cycle from an input beat transfer to m_axis_tvalid. Each packet costs one IDLE bubble cycle.
- Control FIFO:
  - Entry = {tlast, tuser, tkeep, tdata}.
  - Admission is decided on the first beat of a control packet: admit only if free entries ≥ C_CTL_MAX_BEATS, otherwise drop the whole packet, including beats through its tlast.
  - An admitted packet longer than C_CTL_MAX_BEATS: beats beyond the limit are discarded, and the last stored beat gets tlast forced to 1.
- ctl_pkt_cnt: +1 when a tlast beat is written; −1 when a tlast beat is popped; unchanged if both happen in the same cycle. Only complete packets are eligible for grant.
- A simultaneous FIFO write and pop is permitted. Pointers wrap modulo C_CTL_FIFO_DEPTH.
- A data packet is never pre-empted. Control waits for the data packet's tlast, and vice versa.

Optional Feature:
- Macro PKT_MERGE_DROP_CNT_EN.
- When defined:
  - Adds output port ctl_drop_cnt [31:0].
  - Increments once per control packet dropped by admission; saturates at 0xFFFFFFFF.
  - Truncation increments it by one as well.
  - Reset value 0.
- When undefined: the port and counter do not exist; drop behaviour is unchanged.

Test Plan:
- Data only: 3-beat packet, tdata = 0x11/0x22/0x33, m_axis_tready=1 → output beats appear one cycle after each transfer, tlast on 0x33, one bubble before the next packet.
- Control priority: 2-beat control packet (0xA1, 0xA2) written while a 4-beat data packet is in progress → data completes uninterrupted, then 0xA1/0xA2 are output. Data tready stays low until the control packet has drained.
- Back-pressure: m_axis_tready toggles 1,0,0,1 during a data packet → m_axis_tdata stays stable while stalled, no beat lost or duplicated, s_axis_tready tracks the stalls.
- Overflow: m_axis_tready=0, 9 control packets of 4 beats with depth 32 → first 8 packets buffered, 9th dropped (ctl_drop_cnt=1 when PKT_MERGE_DROP_CNT_EN is defined). After release, exactly 8 packets are output in order.
- Truncation: 6-beat control packet with C_CTL_MAX_BEATS=4 → 4 beats output, 4th with tlast=1.
- Reset mid-packet: assert areset during beat 2 of a 3-beat data packet → m_axis_tvalid=0 immediately. A new packet after release is forwarded normally.
